// File: rtl/alu_3_issue_ctrl.sv
// Issue controller for the alu_3 metadata ALU: buffers {meta, action} requests,
// issues one operation at a time, returns results over valid/ready, drops lost ops.
module alu_3_issue_ctrl #(
  parameter int STAGE_ID   = 0,
  parameter int ACTION_LEN = 25,
  parameter int META_LEN   = 256,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [META_LEN-1:0]         s_meta_data,
  input  logic [ACTION_LEN-1:0]       s_action,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [META_LEN-1:0]         alu_meta_data,
  output logic                        alu_meta_valid,
  output logic [ACTION_LEN-1:0]       alu_action,
  output logic                        alu_action_valid,
  input  logic [META_LEN-1:0]         alu_result,
  input  logic                        alu_result_valid,
  output logic [META_LEN-1:0]         m_meta_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        timeout_err,
  output logic [15:0]                 err_cnt
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int WD_W    = $clog2(TIMEOUT + 1);
  localparam int ENTRY_W = META_LEN + ACTION_LEN;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("alu_3_issue_ctrl: FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (TIMEOUT < 6) begin : g_bad_timeout
    $error("alu_3_issue_ctrl: TIMEOUT must be at least 6");
  end
  if (STAGE_ID < 0) begin : g_bad_stage
    $error("alu_3_issue_ctrl: STAGE_ID must be non-negative");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [ENTRY_W-1:0] head;
  logic               head_vis_q;
  logic [WD_W-1:0]    wd_q;
  logic               push;
  logic               pop;
  logic               load_alu;
  logic               clr_wd;
  logic               inc_wd;
  logic               capture;
  logic               drop;
  logic               release_m;

  assign s_ready = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign push    = s_valid && s_ready;
  assign pop     = load_alu;
  assign head    = mem[rd_ptr];

  // Request FIFO: storage carries no reset, only pointers and count do
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {s_meta_data, s_action};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // A written entry becomes visible to the issuer one cycle after it lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_vis_q <= 1'b0;
    end else begin
      head_vis_q <= (fifo_count != '0);
    end
  end

  // Issue FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Issue FSM: next state and per-cycle strobes
  always_comb begin
    state_d   = state_q;
    load_alu  = 1'b0;
    clr_wd    = 1'b0;
    inc_wd    = 1'b0;
    capture   = 1'b0;
    drop      = 1'b0;
    release_m = 1'b0;
    case (state_q)
      IDLE: begin
        if (head_vis_q && (fifo_count != '0)) begin
          load_alu = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        clr_wd  = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (alu_result_valid) begin
          capture = 1'b1;
          state_d = HOLD;
        end else if (wd_q == WD_W'(TIMEOUT)) begin
          drop    = 1'b1;
          state_d = IDLE;
        end else begin
          inc_wd = 1'b1;
        end
      end
      HOLD: begin
        if (m_ready) begin
          release_m = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ALU drive: data holds its last value once the valids drop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_meta_data    <= '0;
      alu_action       <= '0;
      alu_meta_valid   <= 1'b0;
      alu_action_valid <= 1'b0;
    end else begin
      alu_meta_valid   <= load_alu;
      alu_action_valid <= load_alu;
      if (load_alu) begin
        {alu_meta_data, alu_action} <= head;
      end
    end
  end

  // Watchdog and drop reporting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q        <= '0;
      timeout_err <= 1'b0;
      err_cnt     <= '0;
    end else begin
      if (clr_wd) begin
        wd_q <= '0;
      end else if (inc_wd) begin
        wd_q <= wd_q + WD_W'(1);
      end
      timeout_err <= drop;
      if (drop && (err_cnt != 16'hFFFF)) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end

  // Result output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_meta_data <= '0;
      m_valid     <= 1'b0;
    end else begin
      if (capture) begin
        m_meta_data <= alu_result;
        m_valid     <= 1'b1;
      end else if (release_m) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_3_issue_ctrl.sv
// Bench for alu_3_issue_ctrl: a 5-cycle ALU stub plus a queue-based scoreboard
// of accepted requests, result order, latencies and drop events.
module tb_alu_3_issue_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] s_meta_data;
  logic [24:0]  s_action;
  logic         s_valid;
  logic         s_ready;
  logic [255:0] alu_meta_data;
  logic         alu_meta_valid;
  logic [24:0]  alu_action;
  logic         alu_action_valid;
  logic [255:0] alu_result;
  logic         alu_result_valid;
  logic [255:0] m_meta_data;
  logic         m_valid;
  logic         m_ready;
  logic [2:0]   fifo_count;
  logic         timeout_err;
  logic [15:0]  err_cnt;

  alu_3_issue_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .s_meta_data      (s_meta_data),
    .s_action         (s_action),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .alu_meta_data    (alu_meta_data),
    .alu_meta_valid   (alu_meta_valid),
    .alu_action       (alu_action),
    .alu_action_valid (alu_action_valid),
    .alu_result       (alu_result),
    .alu_result_valid (alu_result_valid),
    .m_meta_data      (m_meta_data),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .fifo_count       (fifo_count),
    .timeout_err      (timeout_err),
    .err_cnt          (err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ALU behaviour used by both the stub and the scoreboard
  function automatic logic [255:0] alu_fn(input logic [255:0] m, input logic [24:0] a);
    logic [255:0] r;
    r = m;
    if (a[24:21] == 4'b1100) r[31:24] = a[20:13];
    else r = m + 256'(a);
    return r;
  endfunction

  function automatic logic [255:0] rand_meta();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [24:0] rand_act();
    logic [24:0] a;
    a = 25'($urandom);
    if ($urandom_range(0, 1) == 1) a[24:21] = 4'b1100;
    return a;
  endfunction

  // ALU stub: takes one op every 5 cycles, result valid 4 edges after sampling
  bit           stub_en;
  bit           spur;
  logic [2:0]   stub_cnt;
  logic [255:0] stub_m;
  logic [24:0]  stub_a;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_cnt         <= '0;
      stub_m           <= '0;
      stub_a           <= '0;
      alu_result_valid <= 1'b0;
      alu_result       <= '0;
    end else begin
      alu_result_valid <= 1'b0;
      if (stub_cnt != 0) begin
        stub_cnt <= stub_cnt - 3'd1;
        if (stub_cnt == 3'd1) begin
          alu_result_valid <= 1'b1;
          alu_result       <= alu_fn(stub_m, stub_a);
        end
      end else if (stub_en && alu_action_valid && alu_meta_valid) begin
        stub_cnt <= 3'd4;
        stub_m   <= alu_meta_data;
        stub_a   <= alu_action;
      end
      if (spur) begin
        alu_result_valid <= 1'b1;
        alu_result       <= {8{$urandom}};
      end
    end
  end

  // Event recorder (edge numbers refer to the posedge just before/after the sample)
  logic [255:0] acc_meta[$];
  logic [24:0]  acc_act[$];
  int           acc_t[$];
  int           rise_t[$];
  int           issue_t[$];
  int           to_t[$];
  logic [255:0] got_q[$];
  int           stall_n;
  int           max_cnt;
  int           unstable;
  bit           m_valid_prev;
  bit           clr_req;
  bit           watch_en;
  logic [255:0] watch_val;

  always @(negedge clk) begin
    if (clr_req) begin
      acc_meta.delete(); acc_act.delete(); acc_t.delete(); rise_t.delete();
      issue_t.delete(); to_t.delete(); got_q.delete();
      stall_n = 0; max_cnt = 0; unstable = 0;
    end
    if (rst_n) begin
      if (s_valid && s_ready) begin
        acc_meta.push_back(s_meta_data);
        acc_act.push_back(s_action);
        acc_t.push_back(cyc + 1);
      end
      if (m_valid && !m_valid_prev) rise_t.push_back(cyc);
      if (m_valid && m_ready) got_q.push_back(m_meta_data);
      if (alu_action_valid) issue_t.push_back(cyc);
      if (timeout_err) to_t.push_back(cyc);
      if (s_valid && !s_ready) stall_n++;
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      if (watch_en && (!m_valid || m_meta_data !== watch_val)) unstable++;
    end
    m_valid_prev = m_valid;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear();
    clr_req = 1'b1;
    cycles(1);
    clr_req = 1'b0;
  endtask

  task automatic send(input logic [255:0] m, input logic [24:0] a);
    bit ok;
    ok = 1'b0;
    s_meta_data = m;
    s_action    = a;
    s_valid     = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = s_ready;
      if (!ok) begin @(posedge clk); #1; end
    end
    check("accept", 256'(ok), 256'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_got(input int n, input int budget);
    for (int i = 0; i < budget && got_q.size() < n; i++) cycles(1);
  endtask

  initial begin
    logic [255:0] ma, mb, mc, md;
    logic [24:0]  aa, ab, ac, ad;
    logic [255:0] tmp;
    int           rexp;
    int           prev;

    rst_n = 1'b0; s_valid = 1'b0; s_meta_data = '0; s_action = '0; m_ready = 1'b0;
    stub_en = 1'b1; spur = 1'b0; clr_req = 1'b0; watch_en = 1'b0; watch_val = '0;
    cycles(3);

    // Reset state
    check("rst_s_ready", 256'(s_ready), 256'd1);
    check("rst_fifo_count", 256'(fifo_count), 256'd0);
    check("rst_alu_valids", 256'({alu_action_valid, alu_meta_valid}), 256'd0);
    check("rst_m_valid", 256'(m_valid), 256'd0);
    check("rst_err", 256'({timeout_err, err_cnt}), 256'd0);
    rst_n = 1'b1;
    m_ready = 1'b1;
    clear();

    // Single directed request
    ma = '0;
    aa = {4'b1100, 8'h2A, 13'h0};
    send(ma, aa);
    wait_got(1, 40);
    cycles(3);
    check("single_count", 256'(got_q.size()), 256'd1);
    check("single_latency", 256'(rise_t[0] - acc_t[0]), 256'd8);
    tmp = got_q[0];
    check("single_byte", 256'(tmp[31:24]), 256'h2A);
    check("single_data", tmp, alu_fn(ma, aa));
    check("single_issues", 256'(issue_t.size()), 256'd1);

    // Six back-to-back random requests: FIFO fills, order and spacing preserved
    clear();
    for (int i = 0; i < 6; i++) send(rand_meta(), rand_act());
    wait_got(6, 150);
    cycles(2);
    check("burst_count", 256'(got_q.size()), 256'd6);
    check("burst_stall_seen", 256'(stall_n > 0), 256'd1);
    check("burst_max_fill", 256'(max_cnt), 256'd4);
    check("burst_unblock", 256'(acc_t[5]), 256'(issue_t[1] + 1));
    prev = -100;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("burst_data%0d", i), got_q[i], alu_fn(acc_meta[i], acc_act[i]));
      rexp = (acc_t[i] + 8 > prev + 8) ? acc_t[i] + 8 : prev + 8;
      check($sformatf("burst_rise%0d", i), 256'(rise_t[i]), 256'(rexp));
      prev = rexp;
    end

    // Downstream stall: result held, nothing further issued
    m_ready = 1'b0;
    clear();
    mb = rand_meta(); ab = rand_act();
    mc = rand_meta(); ac = rand_act();
    send(mb, ab);
    for (int i = 0; i < 40 && rise_t.size() < 1; i++) cycles(1);
    check("hold_rise", 256'(rise_t.size()), 256'd1);
    watch_val = alu_fn(mb, ab);
    watch_en = 1'b1;
    send(mc, ac);
    cycles(18);
    watch_en = 1'b0;
    check("hold_stable", 256'(unstable), 256'd0);
    check("hold_data", m_meta_data, alu_fn(mb, ab));
    check("hold_no_issue", 256'(issue_t.size()), 256'd1);
    check("hold_no_out", 256'(got_q.size()), 256'd0);
    m_ready = 1'b1;
    wait_got(2, 40);
    check("hold_order0", got_q[0], alu_fn(mb, ab));
    check("hold_order1", got_q[1], alu_fn(mc, ac));
    check("hold_issues", 256'(issue_t.size()), 256'd2);

    // Lost operation: ALU ignores the first op, the second completes
    cycles(3);
    clear();
    stub_en = 1'b0;
    mc = rand_meta(); ac = rand_act();
    md = rand_meta(); ad = rand_act();
    send(mc, ac);
    send(md, ad);
    for (int i = 0; i < 40 && issue_t.size() < 1; i++) cycles(1);
    cycles(2);
    stub_en = 1'b1;
    for (int i = 0; i < 40 && to_t.size() < 1; i++) cycles(1);
    check("to_seen", 256'(to_t.size()), 256'd1);
    check("to_time", 256'(to_t[0]), 256'(issue_t[0] + 1 + 16));
    check("to_err_cnt", 256'(err_cnt), 256'd1);
    wait_got(1, 40);
    cycles(2);
    check("to_next_issue", 256'(issue_t[1]), 256'(to_t[0] + 1));
    check("to_next_data", got_q[0], alu_fn(md, ad));
    check("to_single_pulse", 256'(to_t.size()), 256'd1);
    check("to_err_cnt_after", 256'(err_cnt), 256'd1);

    // Spurious ALU valid while idle
    cycles(3);
    clear();
    spur = 1'b1;
    cycles(1);
    spur = 1'b0;
    cycles(10);
    check("spur_no_out", 256'(rise_t.size()), 256'd0);
    check("spur_no_err", 256'({to_t.size() != 0, err_cnt}), 256'd1);
    check("spur_m_valid", 256'(m_valid), 256'd0);

    // Asynchronous reset mid-operation with entries queued
    clear();
    send(rand_meta(), rand_act());
    send(rand_meta(), rand_act());
    send(rand_meta(), rand_act());
    for (int i = 0; i < 40 && issue_t.size() < 1; i++) cycles(1);
    cycles(2);
    check("mid_queued", 256'(fifo_count), 256'(acc_t.size() - issue_t.size()));
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_fifo_count", 256'(fifo_count), 256'd0);
    check("mid_s_ready", 256'(s_ready), 256'd1);
    check("mid_alu_out", {alu_meta_data[230:0], alu_action}, 256'd0);
    check("mid_valids", 256'({alu_action_valid, alu_meta_valid, m_valid, timeout_err}), 256'd0);
    check("mid_m_data", m_meta_data, 256'd0);
    check("mid_err_cnt", 256'(err_cnt), 256'd0);
    cycles(2);
    rst_n = 1'b1;
    clear();
    ma = rand_meta(); aa = rand_act();
    send(ma, aa);
    wait_got(1, 40);
    cycles(12);
    check("post_count", 256'(got_q.size()), 256'd1);
    check("post_latency", 256'(rise_t[0] - acc_t[0]), 256'd8);
    check("post_data", got_q[0], alu_fn(ma, aa));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
